// File: rtl/port_mem_pkg.sv
// Shared types and helpers for the port_mem responder.
// Response record carried by the fixed-latency ack pipeline.
package port_mem_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    localparam logic [7:0] LEN_SINGLE = 8'd0;

    // Address width needed to index a table of the given depth.
    function automatic int port_mem_aw(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/port_mem_resp_pipe.sv
// Fixed-depth shift register of responses.
// Reset discards every in-flight response.
module port_mem_resp_pipe
    import port_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  resp_t i_d,
    output resp_t o_q
);

    resp_t r_q [DEPTH];

    // Shift responses one stage per cycle; clear all stages on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            r_q[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_q[i] <= r_q[i-1];
            end
        end
    end

    assign o_q = r_q[DEPTH-1];

endmodule

// File: rtl/port_mem_responder.sv
// Block-RAM backed target for the 32-bit port protocol.
// Optional refresh stalls: define PORT_MEM_REFRESH_STALL_EN.
module port_mem_responder
    import port_mem_pkg::*;
#(
    parameter int MEM_WORDS      = 4096,
    parameter int RESP_LATENCY   = 2,
    parameter int REFRESH_PERIOD = 780,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  inport_wr_i,
    input  logic        inport_rd_i,
    input  logic [7:0]  inport_len_i,
    input  logic [31:0] inport_addr_i,
    input  logic [31:0] inport_write_data_i,
    output logic        inport_accept_o,
    output logic        inport_ack_o,
    output logic        inport_error_o,
    output logic [31:0] inport_read_data_o
);

    localparam int MEM_AW = port_mem_aw(MEM_WORDS);

    logic [31:0]       r_mem [MEM_WORDS];
    logic [31:0]       w_idx;
    logic [MEM_AW-1:0] w_maddr;
    logic              w_wr;
    logic              w_cmd;
    logic              w_fire;
    logic              w_err;
    logic              w_accept;
    logic              w_unused;
    resp_t             w_resp;
    resp_t             w_q;

    assign w_idx   = {2'b00, inport_addr_i[31:2]};
    assign w_maddr = w_idx[MEM_AW-1:0];
    assign w_wr    = |inport_wr_i;
    assign w_cmd   = w_wr | inport_rd_i;
    assign w_fire  = w_cmd & w_accept;
    assign w_err   = (w_idx >= 32'(MEM_WORDS))
                   | (inport_len_i != LEN_SINGLE);

`ifdef PORT_MEM_REFRESH_STALL_EN
    localparam int CW = port_mem_aw(REFRESH_PERIOD);

    logic [CW-1:0] r_cnt;

    // Free-running refresh phase counter; stall at the start of each period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(REFRESH_PERIOD - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_accept = (r_cnt >= CW'(REFRESH_CYCLES));
    assign w_unused = ^inport_addr_i[1:0];
`else
    logic r_up;

    // Accept everything from the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_up <= 1'b0;
        end else begin
            r_up <= 1'b1;
        end
    end

    assign w_accept = r_up;
    assign w_unused = ^{inport_addr_i[1:0],
                        REFRESH_PERIOD[0],
                        REFRESH_CYCLES[0]};
`endif

    // Byte-lane writes on the accepting edge; errors never touch memory.
    always_ff @(posedge clk_i) begin
        if (w_fire && w_wr && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (inport_wr_i[b]) begin
                    r_mem[w_maddr][8*b +: 8] <= inport_write_data_i[8*b +: 8];
                end
            end
        end
    end

    // Build the response entering the pipe; data only for good reads.
    always_comb begin
        w_resp       = '0;
        w_resp.valid = w_fire;
        w_resp.err   = w_fire & w_err;
        if (w_fire && !w_err && !w_wr) begin
            w_resp.data = r_mem[w_maddr];
        end
    end

    port_mem_resp_pipe #(
        .DEPTH (RESP_LATENCY)
    ) u_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_d    (w_resp),
        .o_q    (w_q)
    );

    assign inport_accept_o    = w_accept;
    assign inport_ack_o       = w_q.valid;
    assign inport_error_o     = w_q.err;
    assign inport_read_data_o = w_q.data;

endmodule
